// File: rtl/dma_pkg.sv
// Shared definitions for the DMA controller: instruction layout, op/type codes,
// address-region bounds and the controller state encoding.
package dma_pkg;

  localparam int unsigned DMA_MEM_TOP  = 191;
  localparam int unsigned DMA_IO1_BASE = 192;
  localparam int unsigned DMA_IO2_BASE = 224;

  localparam int unsigned INS_W    = 26;
  localparam int unsigned OP_LSB   = 24;
  localparam int unsigned TYPE_LSB = 22;
  localparam int unsigned SRC_LSB  = 14;
  localparam int unsigned DST_LSB  = 6;
  localparam int unsigned CNT_LSB  = 0;

  localparam logic [1:0] OP_IO_TO_MEM = 2'b00;
  localparam logic [1:0] OP_FROM_MEM  = 2'b01;
  localparam logic [1:0] TYPE_IO      = 2'b01;
  localparam logic [1:0] TYPE_MEM     = 2'b10;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} dma_state_e;
  typedef enum logic [1:0] {REG_MEM, REG_IO1, REG_IO2} region_e;

endpackage

// File: rtl/dma_addr_decode.sv
// Classifies a bus address into the memory, I/O1 or I/O2 region.
module dma_addr_decode
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned IO1_BASE = DMA_IO1_BASE,
  parameter int unsigned IO2_BASE = DMA_IO2_BASE
) (
  input  logic [ADDR_W-1:0] i_addr,
  output region_e           o_region
);

  always_comb begin
    o_region = REG_MEM;
    if (i_addr >= ADDR_W'(IO2_BASE))      o_region = REG_IO2;
    else if (i_addr >= ADDR_W'(IO1_BASE)) o_region = REG_IO1;
  end

endmodule

// File: rtl/dma_controller.sv
// Bus-owning DMA engine: accepts one instruction in IDLE, then alternates
// READ/WRITE per word and reports live count/pointers to the processor.
module dma_controller
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CNT_W    = 6,
  parameter int unsigned MEM_TOP  = DMA_MEM_TOP,
  parameter int unsigned IO1_BASE = DMA_IO1_BASE,
  parameter int unsigned IO2_BASE = DMA_IO2_BASE
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              grant,
  input  logic [INS_W-1:0]  DMA_instruction,
  output logic              busybus,
  output logic [ADDR_W-1:0] D_address,
  output logic              D_memwrite,
  output logic              D_IOWrite1,
  output logic              D_IOWrite2,
  inout  logic [DATA_W-1:0] databus,
  output logic [CNT_W-1:0]  updated_count,
  output logic [ADDR_W-1:0] next_source,
  output logic [ADDR_W-1:0] next_destination,
  output logic              dma_done,
  output logic              dma_error
);

  localparam int unsigned EXT_W = ADDR_W + 1;

  dma_state_e        r_state;
  logic [ADDR_W-1:0] r_src, r_dst;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_buf;
  logic              r_src_mem, r_dst_mem, r_busy, r_done, r_err;

  logic [1:0]        w_op, w_type;
  logic [ADDR_W-1:0] w_src_in, w_dst_in;
  logic [CNT_W-1:0]  w_cnt_in;
  logic              w_supported, w_src_mem, w_dst_mem;
  logic              w_src_ok, w_dst_ok, w_start, w_wr;
  logic [EXT_W-1:0]  w_src_end, w_dst_end;
  region_e           w_src_region, w_dst_region, w_wdst_region;

  assign w_op     = DMA_instruction[OP_LSB +: 2];
  assign w_type   = DMA_instruction[TYPE_LSB +: 2];
  assign w_src_in = DMA_instruction[SRC_LSB +: ADDR_W];
  assign w_dst_in = DMA_instruction[DST_LSB +: ADDR_W];
  assign w_cnt_in = DMA_instruction[CNT_LSB +: CNT_W];

  always_comb begin
    w_supported = 1'b0;
    w_src_mem   = 1'b0;
    w_dst_mem   = 1'b0;
    case ({w_op, w_type})
      {OP_IO_TO_MEM, TYPE_IO}:  begin w_supported = 1'b1; w_dst_mem = 1'b1; end
      {OP_FROM_MEM,  TYPE_IO}:  begin w_supported = 1'b1; w_src_mem = 1'b1; end
      {OP_FROM_MEM,  TYPE_MEM}: begin w_supported = 1'b1; w_src_mem = 1'b1; w_dst_mem = 1'b1; end
      default: ;
    endcase
  end

  dma_addr_decode #(.ADDR_W(ADDR_W), .IO1_BASE(IO1_BASE), .IO2_BASE(IO2_BASE))
    u_src_dec (.i_addr(w_src_in), .o_region(w_src_region));
  dma_addr_decode #(.ADDR_W(ADDR_W), .IO1_BASE(IO1_BASE), .IO2_BASE(IO2_BASE))
    u_dst_dec (.i_addr(w_dst_in), .o_region(w_dst_region));
  dma_addr_decode #(.ADDR_W(ADDR_W), .IO1_BASE(IO1_BASE), .IO2_BASE(IO2_BASE))
    u_wr_dec  (.i_addr(r_dst),    .o_region(w_wdst_region));

  // One extra bit so a block running past the top of the address space cannot wrap into range.
  assign w_src_end = {1'b0, w_src_in} + EXT_W'(w_cnt_in) - EXT_W'(1);
  assign w_dst_end = {1'b0, w_dst_in} + EXT_W'(w_cnt_in) - EXT_W'(1);
  assign w_src_ok  = w_src_mem ? (w_src_end <= EXT_W'(MEM_TOP)) : (w_src_region != REG_MEM);
  assign w_dst_ok  = w_dst_mem ? (w_dst_end <= EXT_W'(MEM_TOP)) : (w_dst_region != REG_MEM);
  assign w_start   = grant && w_supported && (w_cnt_in != '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_src     <= '0;
      r_dst     <= '0;
      r_cnt     <= '0;
      r_buf     <= '0;
      r_src_mem <= 1'b0;
      r_dst_mem <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            if (w_src_ok && w_dst_ok) begin
              r_src     <= w_src_in;
              r_dst     <= w_dst_in;
              r_cnt     <= w_cnt_in;
              r_src_mem <= w_src_mem;
              r_dst_mem <= w_dst_mem;
              r_busy    <= 1'b1;
              r_state   <= READ;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        READ: begin
          r_buf   <= databus;
          r_state <= WRITE;
        end
        WRITE: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_src_mem) r_src <= r_src + ADDR_W'(1);
          if (r_dst_mem) r_dst <= r_dst + ADDR_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_state <= READ;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_wr = (r_state == WRITE);

  always_comb begin
    case (r_state)
      READ:    D_address = r_src;
      WRITE:   D_address = r_dst;
      default: D_address = 'x;
    endcase
  end

  assign D_memwrite       = w_wr && (w_wdst_region == REG_MEM);
  assign D_IOWrite1       = w_wr && (w_wdst_region == REG_IO1);
  assign D_IOWrite2       = w_wr && (w_wdst_region == REG_IO2);
  assign databus          = w_wr ? r_buf : 'z;
  assign busybus          = r_busy;
  assign dma_done         = r_done;
  assign dma_error        = r_err;
  assign updated_count    = r_cnt;
  assign next_source      = r_src;
  assign next_destination = r_dst;

endmodule

// File: tb/tb_dma_controller.sv
// Directed and randomized bench for dma_controller against a word-level
// transfer model and a bus-attached memory/I/O array.
module tb_dma_controller;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        grant = 1'b0;
  logic [25:0] DMA_instruction = '0;
  logic        busybus, D_memwrite, D_IOWrite1, D_IOWrite2, dma_done, dma_error;
  logic [7:0]  D_address, next_source, next_destination;
  logic [5:0]  updated_count;
  wire  [31:0] databus;

  logic [31:0] tb_mem  [256];
  logic [31:0] ref_mem [256];
  int checks = 0;
  int failures = 0;

  dma_controller #(.ADDR_W(8), .DATA_W(32), .CNT_W(6)) dut (
    .clock(clock), .reset_n(reset_n), .grant(grant), .DMA_instruction(DMA_instruction),
    .busybus(busybus), .D_address(D_address), .D_memwrite(D_memwrite),
    .D_IOWrite1(D_IOWrite1), .D_IOWrite2(D_IOWrite2), .databus(databus),
    .updated_count(updated_count), .next_source(next_source),
    .next_destination(next_destination), .dma_done(dma_done), .dma_error(dma_error)
  );

  always #5 clock = ~clock;

  wire tb_rd = busybus & ~(D_memwrite | D_IOWrite1 | D_IOWrite2);
  assign databus = tb_rd ? tb_mem[D_address] : 'z;

  always @(posedge clock)
    if (D_memwrite | D_IOWrite1 | D_IOWrite2) tb_mem[D_address] <= databus;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] strb_of(input int addr);
    if (addr <= 191) return 32'b100;
    if (addr <= 223) return 32'b010;
    return 32'b001;
  endfunction

  function automatic int mem_mismatches();
    int m = 0;
    for (int a = 0; a < 256; a++) if (tb_mem[a] !== ref_mem[a]) m++;
    return m;
  endfunction

  function automatic logic [31:0] strobes();
    return {29'd0, D_memwrite, D_IOWrite1, D_IOWrite2};
  endfunction

  task automatic run(input logic [1:0] op, input logic [1:0] ty, input logic [7:0] src,
                     input logic [7:0] dst, input logic [5:0] cnt, input bit scramble,
                     input bit b2b, input logic [25:0] next_ins);
    bit sup = 0, smem = 0, dmem = 0, legal;
    int n = int'(cnt);
    int s = int'(src);
    int ds = int'(dst);
    int rd, wr;
    logic [31:0] d;
    if (op == 2'b00 && ty == 2'b01) begin sup = 1; dmem = 1; end
    else if (op == 2'b01 && ty == 2'b01) begin sup = 1; smem = 1; end
    else if (op == 2'b01 && ty == 2'b10) begin sup = 1; smem = 1; dmem = 1; end
    legal = (smem ? (s + n - 1 <= 191) : (s >= 192)) && (dmem ? (ds + n - 1 <= 191) : (ds >= 192));

    DMA_instruction = {op, ty, src, dst, cnt};
    grant = 1'b1;
    @(posedge clock); #1;
    if (!(sup && n != 0)) begin
      chk("ign_busy", 32'(busybus), 0);
      chk("ign_err", 32'(dma_error), 0);
      grant = 1'b0;
      @(posedge clock); #1;
      chk("ign_err2", 32'(dma_error), 0);
      chk("ign_busy2", 32'(busybus), 0);
      return;
    end
    if (!legal) begin
      chk("rej_err", 32'(dma_error), 1);
      chk("rej_busy", 32'(busybus), 0);
      grant = 1'b0;
      @(posedge clock); #1;
      chk("rej_err_end", 32'(dma_error), 0);
      chk("rej_busy2", 32'(busybus), 0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      rd = s + (smem ? i : 0);
      wr = ds + (dmem ? i : 0);
      d = ref_mem[rd];
      ref_mem[wr] = d;
      if (scramble) begin
        DMA_instruction = 26'($urandom);
        grant = 1'($urandom_range(0, 1));
      end else begin
        grant = 1'b0;
      end
      chk("rd_busy", 32'(busybus), 1);
      chk("rd_addr", 32'(D_address), rd);
      chk("rd_strb", strobes(), 0);
      chk("rd_cnt", 32'(updated_count), n - i);
      chk("rd_src", 32'(next_source), rd);
      chk("rd_dst", 32'(next_destination), wr);
      @(posedge clock); #1;
      chk("wr_busy", 32'(busybus), 1);
      chk("wr_addr", 32'(D_address), wr);
      chk("wr_strb", strobes(), strb_of(wr));
      chk("wr_data", databus, d);
      chk("wr_cnt", 32'(updated_count), n - i);
      @(posedge clock); #1;
    end
    chk("done_pulse", 32'(dma_done), 1);
    chk("done_busy", 32'(busybus), 0);
    chk("done_strb", strobes(), 0);
    chk("done_cnt", 32'(updated_count), 0);
    chk("done_src", 32'(next_source), (s + (smem ? n : 0)) % 256);
    chk("done_dst", 32'(next_destination), (ds + (dmem ? n : 0)) % 256);
    if (b2b) begin
      DMA_instruction = next_ins;
      grant = 1'b1;
    end else begin
      grant = 1'b0;
    end
    @(posedge clock); #1;
    chk("idle_done", 32'(dma_done), 0);
    chk("idle_busy", 32'(busybus), 0);
    chk("idle_src", 32'(next_source), (s + (smem ? n : 0)) % 256);
    chk("idle_dst", 32'(next_destination), (ds + (dmem ? n : 0)) % 256);
    chk("mem_image", 32'(mem_mismatches()), 0);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      tb_mem[a]  = $urandom;
      ref_mem[a] = tb_mem[a];
    end

    @(posedge clock); #1;
    chk("rst_busy", 32'(busybus), 0);
    chk("rst_cnt", 32'(updated_count), 0);
    chk("rst_src", 32'(next_source), 0);
    chk("rst_dst", 32'(next_destination), 0);
    chk("rst_flags", {30'd0, dma_done, dma_error}, 0);
    reset_n = 1'b1;

    // Reset asserted during the second WRITE of a 4-word mem->mem block.
    DMA_instruction = {2'b01, 2'b10, 8'd20, 8'd60, 6'd4};
    grant = 1'b1;
    @(posedge clock); #1;
    grant = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("mid_wr_addr", 32'(D_address), 61);
    chk("mid_wr_strb", strobes(), 32'b100);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busybus), 0);
    chk("arst_strb", strobes(), 0);
    chk("arst_cnt", 32'(updated_count), 0);
    chk("arst_ptrs", {16'd0, next_source, next_destination}, 0);
    ref_mem[60] = ref_mem[20];
    @(posedge clock); #3;
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("arst_idle", 32'(busybus), 0);
    chk("arst_mem", 32'(mem_mismatches()), 0);

    run(2'b01, 2'b10, 8'd10,  8'd100, 6'd3, 0, 0, '0);
    run(2'b01, 2'b01, 8'd0,   8'd230, 6'd2, 0, 0, '0);
    run(2'b00, 2'b01, 8'd200, 8'd190, 6'd2, 0, 0, '0);
    run(2'b01, 2'b10, 8'd190, 8'd50,  6'd5, 0, 0, '0);
    run(2'b01, 2'b10, 8'd10,  8'd20,  6'd0, 0, 0, '0);
    run(2'b10, 2'b01, 8'd10,  8'd20,  6'd3, 0, 0, '0);
    run(2'b01, 2'b11, 8'd10,  8'd20,  6'd3, 0, 0, '0);
    run(2'b01, 2'b10, 8'd187, 8'd189, 6'd3, 0, 0, '0);
    run(2'b01, 2'b10, 8'd188, 8'd0,   6'd5, 0, 0, '0);
    run(2'b00, 2'b01, 8'd191, 8'd10,  6'd1, 0, 0, '0);
    run(2'b01, 2'b01, 8'd250, 8'd200, 6'd10, 0, 0, '0);
    run(2'b01, 2'b10, 8'd30,  8'd120, 6'd3, 1, 1, {2'b01, 2'b01, 8'd5, 8'd200, 6'd2});
    run(2'b01, 2'b01, 8'd5,   8'd200, 6'd2, 0, 0, '0);

    for (int k = 0; k < 25; k++) begin
      logic [1:0] op, ty;
      logic [7:0] src, dst;
      int kind = $urandom_range(0, 4);
      case (kind)
        0: begin op = 2'b00; ty = 2'b01; end
        1: begin op = 2'b01; ty = 2'b01; end
        2: begin op = 2'b01; ty = 2'b10; end
        3: begin op = 2'b11; ty = 2'b10; end
        default: begin op = 2'b00; ty = 2'b00; end
      endcase
      src = (kind == 0) ? 8'($urandom_range(185, 255)) : 8'($urandom_range(0, 195));
      dst = (kind == 1) ? 8'($urandom_range(185, 255)) : 8'($urandom_range(0, 195));
      run(op, ty, src, dst, 6'($urandom_range(0, 9)), 1'($urandom_range(0, 1)), 0, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
